z80_int_ctrl: RTL and testbench

//  Z80 IM2 interrupt controller and I/O-read responder for the CPLD bus glue.

---
 rtl/z80_int_ctrl_if.sv | 25 ++
 rtl/z80_int_ctrl.sv | 165 ++++++++++++++++
 tb/tb_z80_int_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_int_ctrl_if.sv
// Z80 bus bundle between the CPU-side bus glue and the IM2 interrupt controller.
// Strobes are the raw active-low Z80 signals; the controller synchronizes them itself.
interface z80_int_ctrl_if;
    logic       iorq_n;
    logic       m1_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] a;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic       int_n;
    logic       u_int;
    logic [1:0] ext_irq;

    modport master (
        output iorq_n, m1_n, rd_n, wr_n, a, d_in, u_int, ext_irq,
        input  d_out, d_oe, int_n
    );

    modport slave (
        input  iorq_n, m1_n, rd_n, wr_n, a, d_in, u_int, ext_irq,
        output d_out, d_oe, int_n
    );
endinterface

// File: rtl/z80_int_ctrl.sv
// Z80 IM2 interrupt controller: four sources, mask/pending/vector registers on IO ports,
// INT_n generation and vector drive during the M1+IORQ acknowledge cycle.
module z80_int_ctrl #(
    parameter logic [7:0]  VecBase  = 8'hE0,
    parameter int unsigned TimerDiv = 480000,
    parameter logic [7:0]  PortMask = 8'h14,
    parameter logic [7:0]  PortPend = 8'h15,
    parameter logic [7:0]  PortVec  = 8'h16
) (
    input logic            clk_24mhz_i,
    input logic            res_ni,
    z80_int_ctrl_if.slave  bus_if
);

    localparam int unsigned TimerW = (TimerDiv > 1) ? $clog2(TimerDiv) : 1;
    // Bit order: {ext_irq[1:0], u_int, wr_n, rd_n, m1_n, iorq_n}; strobes idle high.
    localparam logic [6:0] SyncIdle = 7'b00_0_1111;

    typedef enum logic [1:0] {StIdle, StAssert, StAck, StHold} state_e;

    logic [6:0]        sync1_q, sync2_q;
    logic              wr_act_q;
    logic [1:0]        ext_prev_q;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        mask_q, mask_d;
    logic [3:0]        pend_q, pend_d;
    logic [4:0]        vbase_q, vbase_d;
    state_e            state_q;
    logic              int_n_q;
    logic              d_oe_q;
    logic [7:0]        d_out_q;

    logic       s_iorq, s_m1, s_rd, s_wr, s_u_int;
    logic [1:0] s_ext;
    logic       wr_act, wr_stb, rd_hit, tick, req, intack, ack_enter, ack_hold;
    logic [1:0] ext_rise;
    logic [3:0] active, pend_clr;
    logic [1:0] ack_id;
    logic [7:0] rd_data;

    assign s_iorq  = sync2_q[0];
    assign s_m1    = sync2_q[1];
    assign s_rd    = sync2_q[2];
    assign s_wr    = sync2_q[3];
    assign s_u_int = sync2_q[4];
    assign s_ext   = sync2_q[6:5];

    always_ff @(posedge clk_24mhz_i or negedge res_ni) begin
        if (!res_ni) begin
            sync1_q <= SyncIdle;
            sync2_q <= SyncIdle;
        end else begin
            sync1_q <= {bus_if.ext_irq, bus_if.u_int, bus_if.wr_n, bus_if.rd_n,
                        bus_if.m1_n, bus_if.iorq_n};
            sync2_q <= sync1_q;
        end
    end

    // M1 low suppresses decode so an acknowledge is never mistaken for a port access.
    assign wr_act    = !s_iorq && !s_wr && s_m1;
    assign wr_stb    = wr_act && !wr_act_q;
    assign rd_hit    = !s_iorq && !s_rd && s_m1 &&
                       (bus_if.a == PortMask || bus_if.a == PortPend || bus_if.a == PortVec);
    assign tick      = (timer_q == TimerW'(TimerDiv - 1));
    assign ext_rise  = s_ext & ~ext_prev_q;
    assign active    = pend_q & mask_q;
    assign req       = |active;
    assign intack    = !s_m1 && !s_iorq;
    assign ack_enter = (state_q == StAssert) && req && intack;
    assign ack_hold  = (state_q == StAck) && !s_iorq && !s_m1;

    always_comb begin
        ack_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (active[i]) ack_id = 2'(i);
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (bus_if.a == PortMask)      rd_data = {4'b0, mask_q};
        else if (bus_if.a == PortPend) rd_data = {4'b0, pend_q};
        else if (bus_if.a == PortVec)  rd_data = {vbase_q, 3'b0};
    end

    always_comb begin
        pend_clr = 4'b0;
        if (wr_stb && bus_if.a == PortPend) pend_clr[3:1] = bus_if.d_in[3:1];
        if (ack_enter && ack_id != 2'd0) pend_clr[ack_id] = 1'b1;
        // Sets are OR-ed in after clears so a coincident set wins.
        pend_d    = (pend_q & ~pend_clr) | {ext_rise, tick, 1'b0};
        pend_d[0] = s_u_int;

        mask_d  = mask_q;
        vbase_d = vbase_q;
        if (wr_stb && bus_if.a == PortMask) mask_d  = bus_if.d_in[3:0];
        if (wr_stb && bus_if.a == PortVec)  vbase_d = bus_if.d_in[7:3];

        timer_d = tick ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk_24mhz_i or negedge res_ni) begin
        if (!res_ni) begin
            wr_act_q   <= 1'b0;
            ext_prev_q <= 2'b0;
            timer_q    <= '0;
            mask_q     <= 4'b0;
            pend_q     <= 4'b0;
            vbase_q    <= VecBase[7:3];
        end else begin
            wr_act_q   <= wr_act;
            ext_prev_q <= s_ext;
            timer_q    <= timer_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            vbase_q    <= vbase_d;
        end
    end

    always_ff @(posedge clk_24mhz_i or negedge res_ni) begin
        if (!res_ni) begin
            state_q <= StIdle;
            int_n_q <= 1'b1;
            d_oe_q  <= 1'b0;
            d_out_q <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        state_q <= StAssert;
                        int_n_q <= 1'b0;
                    end
                end
                StAssert: begin
                    if (!req) begin
                        state_q <= StIdle;
                        int_n_q <= 1'b1;
                    end else if (intack) begin
                        state_q <= StAck;
                        int_n_q <= 1'b1;
                    end
                end
                StAck: begin
                    if (s_iorq || s_m1) state_q <= StHold;
                end
                StHold: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            // The vector is captured once on entry so it cannot change mid-acknowledge.
            if (ack_enter) begin
                d_oe_q  <= 1'b1;
                d_out_q <= {vbase_q, ack_id, 1'b0};
            end else if (!ack_hold) begin
                d_oe_q  <= rd_hit;
                d_out_q <= rd_hit ? rd_data : 8'h00;
            end
        end
    end

    assign bus_if.int_n = int_n_q;
    assign bus_if.d_oe  = d_oe_q;
    assign bus_if.d_out = d_out_q;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Bench for z80_int_ctrl: directed scenarios plus random bus traffic, all checked every
// cycle against a cycle-level behavioural model of the controller.
module tb_z80_int_ctrl;

    localparam int TDIV = 300;

    typedef struct packed {
        logic       iorq;
        logic       m1;
        logic       rd;
        logic       wr;
        logic       u;
        logic [1:0] ext;
    } smp_t;

    localparam smp_t IdleSmp = '{iorq: 1'b1, m1: 1'b1, rd: 1'b1, wr: 1'b1, u: 1'b0, ext: 2'b00};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    z80_int_ctrl_if bus_if();

    z80_int_ctrl #(.TimerDiv(TDIV)) dut (
        .clk_24mhz_i (clk),
        .res_ni      (rst_n),
        .bus_if      (bus_if)
    );

    always #5 clk = ~clk;

    // Model state: sample history gives the two-flop synchronizer delay.
    smp_t hist [4];
    int   m_mask, m_pend, m_vbase, m_timer, m_phase, m_dout;
    bit   m_int, m_oe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = IdleSmp;
        m_mask = 0; m_pend = 0; m_vbase = 8'hE0; m_timer = 0; m_phase = 0;
        m_int = 1'b1; m_oe = 1'b0; m_dout = 0;
    endtask

    task automatic model_step();
        smp_t s, p;
        int act, id, np, a, d;
        bit wstb, rd, ack, is_port;
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0];
        hist[0] = '{iorq: bus_if.iorq_n, m1: bus_if.m1_n, rd: bus_if.rd_n, wr: bus_if.wr_n,
                    u: bus_if.u_int, ext: bus_if.ext_irq};
        s = hist[2];
        p = hist[3];
        a = int'(bus_if.a);
        d = int'(bus_if.d_in);
        wstb = (!s.iorq && !s.wr && s.m1) && !(!p.iorq && !p.wr && p.m1);
        rd = !s.iorq && !s.rd && s.m1;
        is_port = (a == 'h14) || (a == 'h15) || (a == 'h16);
        act = m_pend & m_mask;
        id = 0;
        for (int i = 3; i >= 0; i--) if (act[i]) id = i;
        ack = (m_phase == 1) && (act != 0) && !s.m1 && !s.iorq;

        if (ack) begin
            m_oe = 1'b1;
            m_dout = m_vbase + id * 2;
        end else if (m_phase == 2 && !s.iorq && !s.m1) begin
            // vector held
        end else if (rd && is_port) begin
            m_oe = 1'b1;
            m_dout = (a == 'h14) ? m_mask : (a == 'h15) ? m_pend : m_vbase;
        end else begin
            m_oe = 1'b0;
            m_dout = 0;
        end

        case (m_phase)
            0: if (act != 0) m_phase = 1;
            1: if (act == 0) m_phase = 0; else if (ack) m_phase = 2;
            2: if (s.iorq || s.m1) m_phase = 3;
            default: m_phase = 0;
        endcase
        m_int = (m_phase != 1);

        np = m_pend;
        if (wstb && a == 'h15) np = np & ~(d & 'hE);
        if (ack && id != 0) np = np & ~(1 << id);
        if (m_timer == TDIV - 1) np = np | 2;
        if (s.ext[0] && !p.ext[0]) np = np | 4;
        if (s.ext[1] && !p.ext[1]) np = np | 8;
        m_pend = (np & 'hE) | int'(s.u);
        if (wstb && a == 'h14) m_mask = d & 'hF;
        if (wstb && a == 'h16) m_vbase = d & 'hF8;
        m_timer = (m_timer + 1) % TDIV;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        if (rst_n) begin
            check("int_n", bus_if.int_n, m_int);
            check("d_oe", bus_if.d_oe, m_oe);
            if (m_oe) check("d_out", bus_if.d_out, m_dout);
        end
    end

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        @(negedge clk);
        bus_if.a = port; bus_if.d_in = data; bus_if.iorq_n = 1'b0; bus_if.wr_n = 1'b0;
        repeat (5) @(negedge clk);
        bus_if.iorq_n = 1'b1; bus_if.wr_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic io_read(input logic [7:0] port, output logic [7:0] val, output bit seen);
        seen = 1'b0; val = 8'h00;
        @(negedge clk);
        bus_if.a = port; bus_if.iorq_n = 1'b0; bus_if.rd_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.d_oe && !seen) begin seen = 1'b1; val = bus_if.d_out; end
        end
        bus_if.iorq_n = 1'b1; bus_if.rd_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic intack(output logic [7:0] vec, output bit seen);
        seen = 1'b0; vec = 8'h00;
        @(negedge clk);
        bus_if.m1_n = 1'b0;
        @(negedge clk);
        bus_if.iorq_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.d_oe && !seen) begin seen = 1'b1; vec = bus_if.d_out; end
        end
        bus_if.iorq_n = 1'b1; bus_if.m1_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_int_low(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clk);
            if (bus_if.int_n == 1'b0) ok = 1'b1;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        bit seen, ok;
        logic [7:0] ports [4];
        bus_if.iorq_n = 1'b1; bus_if.m1_n = 1'b1; bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
        bus_if.a = 8'h00; bus_if.d_in = 8'h00; bus_if.u_int = 1'b0; bus_if.ext_irq = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset values
        check("rst_int_n", bus_if.int_n, 1'b1);
        check("rst_d_oe", bus_if.d_oe, 1'b0);
        io_read(8'h14, v, seen); check("rd_mask_seen", seen, 1'b1); check("rd_mask", v, 8'h00);
        io_read(8'h15, v, seen); check("rd_pend_seen", seen, 1'b1); check("rd_pend", v, 8'h00);
        io_read(8'h16, v, seen); check("rd_vec_seen", seen, 1'b1); check("rd_vec", v, 8'hE0);
        io_read(8'h13, v, seen); check("rd_other_no_oe", seen, 1'b0);

        // 2: timer source
        io_write(8'h14, 8'h02);
        wait_int_low(TDIV + 50, ok); check("timer_int", ok, 1'b1);
        io_read(8'h15, v, seen); check("timer_pend", v, 8'h02);
        intack(v, seen); check("timer_ack_seen", seen, 1'b1); check("timer_vec", v, 8'hE2);
        io_read(8'h15, v, seen); check("timer_pend_clr", v, 8'h00);
        check("timer_int_hi", bus_if.int_n, 1'b1);

        // 3: priority of the level source over an edge source
        io_write(8'h14, 8'h0D);
        bus_if.u_int = 1'b1; bus_if.ext_irq = 2'b01;
        wait_int_low(20, ok); check("prio_int", ok, 1'b1);
        intack(v, seen); check("prio_vec0", v, 8'hE0);
        wait_int_low(20, ok); check("prio_reassert", ok, 1'b1);
        bus_if.u_int = 1'b0;
        repeat (6) @(negedge clk);
        intack(v, seen); check("prio_vec2", v, 8'hE4);

        // 4: vector base change
        io_write(8'h16, 8'hA8);
        bus_if.ext_irq = 2'b11;
        io_write(8'h14, 8'h08);
        wait_int_low(20, ok); check("vb_int", ok, 1'b1);
        intack(v, seen); check("vb_vec", v, 8'hAE);

        // 5: W1C drops INT; W1C coincident with a new edge keeps the bit
        bus_if.ext_irq = 2'b10;
        repeat (4) @(negedge clk);
        io_write(8'h14, 8'h04);
        bus_if.ext_irq = 2'b11;
        wait_int_low(20, ok); check("w1c_int", ok, 1'b1);
        io_write(8'h15, 8'h04);
        check("w1c_int_hi", bus_if.int_n, 1'b1);
        bus_if.ext_irq = 2'b10;
        repeat (4) @(negedge clk);
        @(negedge clk);
        bus_if.a = 8'h15; bus_if.d_in = 8'h04; bus_if.iorq_n = 1'b0; bus_if.wr_n = 1'b0;
        bus_if.ext_irq = 2'b11;
        repeat (5) @(negedge clk);
        bus_if.iorq_n = 1'b1; bus_if.wr_n = 1'b1;
        repeat (4) @(negedge clk);
        io_read(8'h15, v, seen); check("w1c_set_wins", v & 8'h04, 8'h04);
        io_write(8'h15, 8'h0E);
        io_write(8'h14, 8'h00);

        // 6: asynchronous reset during acknowledge
        io_write(8'h14, 8'h08);
        bus_if.ext_irq = 2'b00;
        repeat (4) @(negedge clk);
        bus_if.ext_irq = 2'b10;
        wait_int_low(20, ok); check("rst_ack_int", ok, 1'b1);
        @(negedge clk);
        bus_if.m1_n = 1'b0; bus_if.iorq_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.d_oe) seen = 1'b1;
        end
        check("rst_ack_oe", seen, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_oe", bus_if.d_oe, 1'b0);
        check("rst_async_int", bus_if.int_n, 1'b1);
        @(negedge clk);
        bus_if.m1_n = 1'b1; bus_if.iorq_n = 1'b1; bus_if.ext_irq = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        io_read(8'h14, v, seen); check("rst2_mask", v, 8'h00);
        io_read(8'h15, v, seen); check("rst2_pend", v, 8'h00);
        io_read(8'h16, v, seen); check("rst2_vec", v, 8'hE0);

        // Random traffic, checked by the per-cycle model
        for (int n = 0; n < 250; n++) begin
            int unsigned r;
            ports[0] = 8'h14; ports[1] = 8'h15; ports[2] = 8'h16; ports[3] = 8'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0, 1: io_write(ports[$urandom_range(0, 3)], 8'($urandom));
                2, 3: io_read(ports[$urandom_range(0, 3)], v, seen);
                4: if (bus_if.int_n == 1'b0) intack(v, seen);
                5: bus_if.u_int = 1'($urandom);
                6: bus_if.ext_irq = 2'($urandom);
                default: repeat ($urandom_range(1, 6)) @(negedge clk);
            endcase
        end

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
